// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_n_out_slot.sv
// One-entry output buffer for a single demux channel; a load takes priority over a drain,
// so the slot can hand off its current beat and accept the next one on the same edge.
module demux_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/stream_demux_n.sv
// 1-to-CHANNELS valid/ready demux with per-channel buffering, packet select lock and drop counter.
//   state   | meaning
//   ST_IDLE | no packet open, In_sel steers the beat
//   ST_PKT  | packet open, beats follow the latched select until the last beat
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int SEL_W       = 2,
  parameter int PACKET_MODE = 1,
  parameter int CNT_W       = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [WIDTH-1:0]          in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [SEL_W-1:0]          in_sel_i,
  input  logic                      in_last_i,
  output logic [CHANNELS*WIDTH-1:0] y_data_o,
  output logic [CHANNELS-1:0]       y_last_o,
  output logic [CHANNELS-1:0]       y_valid_o,
  input  logic [CHANNELS-1:0]       y_ready_i,
  output logic [CNT_W-1:0]          drop_count_o,
  output logic                      busy_o
);

  if (CHANNELS < 2 || SEL_W < clog2(CHANNELS)) begin : g_param_check
    $error("stream_demux_n: need CHANNELS >= 2 and 2**SEL_W >= CHANNELS");
  end

  state_t              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic                busy_q;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [SEL_W-1:0]    eff_sel;
  logic [CHANNELS-1:0] slot_free;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] load;
  logic                sel_free;
  logic                in_range;
  logic                accept;

  assign eff_sel   = (PACKET_MODE != 0 && state_q == ST_PKT) ? sel_q : in_sel_i;
  assign slot_free = ~y_valid_o | y_ready_i;

  // An out-of-range select matches no slot, so it leaves sel_free at 1 and the beat is sunk.
  always_comb begin
    hit      = '0;
    sel_free = 1'b1;
    in_range = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      hit[k] = (eff_sel == SEL_W'(k));
      if (hit[k]) begin
        sel_free = slot_free[k];
        in_range = 1'b1;
      end
    end
  end

  assign in_ready_o = ~reset_i & sel_free;
  assign accept     = in_valid_i & in_ready_o;
  assign load       = hit & {CHANNELS{accept}};

  always_comb begin
    drop_d = drop_q;
    if (accept && !in_range && !(&drop_q)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) drop_q <= '0;
    else         drop_q <= drop_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else if (PACKET_MODE != 0 && accept) begin
      case (state_q)
        ST_IDLE: begin
          if (!in_last_i) begin
            state_q <= ST_PKT;
            sel_q   <= in_sel_i;
            busy_q  <= 1'b1;
          end
        end
        ST_PKT: begin
          if (in_last_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load_i  (load[k]),
      .data_i  (in_data_i),
      .last_i  (in_last_i),
      .ready_i (y_ready_i[k]),
      .valid_o (y_valid_o[k]),
      .data_o  (y_data_o[k*WIDTH +: WIDTH]),
      .last_o  (y_last_o[k])
    );
  end

  assign drop_count_o = drop_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: a 4-channel and a 3-channel instance share one input stream.
module tb_stream_demux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last;
  logic [1:0]  in_sel;
  logic [3:0]  yr4;
  logic [2:0]  yr3;

  logic        rdy4, rdy3, busy4, busy3;
  logic [31:0] yd4;
  logic [23:0] yd3;
  logic [3:0]  yl4, yv4;
  logic [2:0]  yl3, yv3;
  logic [7:0]  dc4, dc3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_demux_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .PACKET_MODE(1), .CNT_W(8)) dut4 (
    .clk_i(clk), .reset_i(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(rdy4),
    .in_sel_i(in_sel), .in_last_i(in_last), .y_data_o(yd4), .y_last_o(yl4), .y_valid_o(yv4),
    .y_ready_i(yr4), .drop_count_o(dc4), .busy_o(busy4));

  stream_demux_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .PACKET_MODE(1), .CNT_W(8)) dut3 (
    .clk_i(clk), .reset_i(rst), .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(rdy3),
    .in_sel_i(in_sel), .in_last_i(in_last), .y_data_o(yd3), .y_last_o(yl3), .y_valid_o(yv3),
    .y_ready_i(yr3), .drop_count_o(dc3), .busy_o(busy3));

  // Reference model: each channel is a one-beat mailbox, plus an "open packet" destination.
  bit         m_vld [2][4];
  logic [7:0] m_dat [2][4];
  bit         m_lst [2][4];
  bit         m_open[2];
  int         m_ch  [2];
  int         m_drop[2];
  int         nch   [2] = '{4, 3};

  function automatic bit yr_bit(int i, int k);
    return (i == 0) ? yr4[k] : yr3[k];
  endfunction

  function automatic int m_dest(int i);
    return m_open[i] ? m_ch[i] : int'(in_sel);
  endfunction

  function automatic bit m_rdy(int i);
    int s;
    if (rst) return 1'b0;
    s = m_dest(i);
    if (s >= nch[i]) return 1'b1;
    return !m_vld[i][s] || yr_bit(i, s);
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int s;
      bit acc;
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          m_vld[i][k] = 0; m_dat[i][k] = 8'h00; m_lst[i][k] = 0;
        end
        m_open[i] = 0; m_ch[i] = 0; m_drop[i] = 0;
      end else begin
        s   = m_dest(i);
        acc = in_valid && m_rdy(i);
        for (int k = 0; k < nch[i]; k++)
          if (m_vld[i][k] && yr_bit(i, k)) m_vld[i][k] = 0;
        if (acc) begin
          if (s < nch[i]) begin
            m_vld[i][s] = 1; m_dat[i][s] = in_data; m_lst[i][s] = in_last;
          end else if (m_drop[i] < 255) begin
            m_drop[i]++;
          end
          if (!m_open[i] && !in_last) begin
            m_open[i] = 1; m_ch[i] = int'(in_sel);
          end else if (m_open[i] && in_last) begin
            m_open[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("m_rdy4", {31'd0, rdy4}, {31'd0, m_rdy(0)});
    chk("m_rdy3", {31'd0, rdy3}, {31'd0, m_rdy(1)});
    chk("m_busy4", {31'd0, busy4}, {31'd0, m_open[0]});
    chk("m_busy3", {31'd0, busy3}, {31'd0, m_open[1]});
    chk("m_drop4", {24'd0, dc4}, m_drop[0]);
    chk("m_drop3", {24'd0, dc3}, m_drop[1]);
    for (int k = 0; k < 4; k++) begin
      chk("m_yv4", {31'd0, yv4[k]}, {31'd0, m_vld[0][k]});
      chk("m_yd4", {24'd0, yd4[k*8 +: 8]}, {24'd0, m_dat[0][k]});
      chk("m_yl4", {31'd0, yl4[k]}, {31'd0, m_lst[0][k]});
    end
    for (int k = 0; k < 3; k++) begin
      chk("m_yv3", {31'd0, yv3[k]}, {31'd0, m_vld[1][k]});
      chk("m_yd3", {24'd0, yd3[k*8 +: 8]}, {24'd0, m_dat[1][k]});
      chk("m_yl3", {31'd0, yl3[k]}, {31'd0, m_lst[1][k]});
    end
  endtask

  typedef struct {
    bit         v;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] yr;
    bit         e_rdy;
    logic [3:0] e_yv;
    int         ch;
    logic [7:0] e_d;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // routing 0xA0..0xA3, then backpressure on channel 2
    tbl[0] = '{1, 2'd0, 8'hA0, 4'b1111, 1, 4'b0001, 0, 8'hA0};
    tbl[1] = '{1, 2'd1, 8'hA1, 4'b1111, 1, 4'b0010, 1, 8'hA1};
    tbl[2] = '{1, 2'd2, 8'hA2, 4'b1111, 1, 4'b0100, 2, 8'hA2};
    tbl[3] = '{1, 2'd3, 8'hA3, 4'b1111, 1, 4'b1000, 3, 8'hA3};
    tbl[4] = '{1, 2'd2, 8'h11, 4'b1011, 1, 4'b0100, 2, 8'h11};
    tbl[5] = '{1, 2'd2, 8'h22, 4'b1011, 0, 4'b0100, 2, 8'h11};
    tbl[6] = '{1, 2'd2, 8'h22, 4'b1111, 1, 4'b0100, 2, 8'h22};
    tbl[7] = '{0, 2'd2, 8'h00, 4'b1111, 1, 4'b0000, 2, 8'h22};

    rst = 1; in_valid = 0; in_last = 0; in_sel = 0; in_data = 0; yr4 = 0; yr3 = 0;
    @(negedge clk);
    tick(); tick();
    rst = 0;

    // T1: traffic, open packet and a drop, then reset for two cycles
    in_valid = 1; in_sel = 3; in_last = 1; in_data = 8'h33;
    tick();
    in_sel = 1; in_last = 0; in_data = 8'h5A;
    #1 chk("t1_rdy_pre", {31'd0, rdy4}, 32'd1);
    tick();
    #1;
    chk("t1_busy_pre", {31'd0, busy4}, 32'd1);
    chk("t1_yv_pre", {28'd0, yv4}, 32'h0A);
    chk("t1_drop_pre", {24'd0, dc3}, 32'd1);
    rst = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t1_rdy4_rst", {31'd0, rdy4}, 32'd0);
      chk("t1_rdy3_rst", {31'd0, rdy3}, 32'd0);
      tick();
    end
    rst = 0; in_valid = 0;
    #1;
    chk("t1_yv4", {28'd0, yv4}, 32'd0);
    chk("t1_yv3", {29'd0, yv3}, 32'd0);
    chk("t1_yd4", yd4, 32'd0);
    chk("t1_drop3", {24'd0, dc3}, 32'd0);
    chk("t1_drop4", {24'd0, dc4}, 32'd0);
    chk("t1_busy4", {31'd0, busy4}, 32'd0);
    chk("t1_busy3", {31'd0, busy3}, 32'd0);

    // T2/T3 table
    yr3 = 3'b111; in_last = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].v; in_sel = tbl[i].sel; in_data = tbl[i].d; yr4 = tbl[i].yr;
      #1 chk("tbl_rdy", {31'd0, rdy4}, {31'd0, tbl[i].e_rdy});
      tick();
      #1;
      chk("tbl_yv", {28'd0, yv4}, {28'd0, tbl[i].e_yv});
      chk("tbl_yd", {24'd0, yd4[tbl[i].ch*8 +: 8]}, {24'd0, tbl[i].e_d});
    end

    // T4: packet lock on channel 1 while In_sel wanders
    yr4 = 4'b1111; in_valid = 1;
    in_sel = 1; in_last = 0; in_data = 8'h41;
    tick();
    #1;
    chk("t4_busy1", {31'd0, busy4}, 32'd1);
    chk("t4_yv1", {28'd0, yv4}, 32'h2);
    chk("t4_yd1", {24'd0, yd4[15:8]}, 32'h41);
    in_sel = 3; in_data = 8'h42;
    #1 chk("t4_rdy2", {31'd0, rdy4}, 32'd1);
    tick();
    #1;
    chk("t4_yv2", {28'd0, yv4}, 32'h2);
    chk("t4_yd2", {24'd0, yd4[15:8]}, 32'h42);
    chk("t4_busy2", {31'd0, busy4}, 32'd1);
    in_sel = 0; in_last = 1; in_data = 8'h43;
    tick();
    #1;
    chk("t4_yv3", {28'd0, yv4}, 32'h2);
    chk("t4_yd3", {24'd0, yd4[15:8]}, 32'h43);
    chk("t4_yl3", {31'd0, yl4[1]}, 32'd1);
    chk("t4_busy3", {31'd0, busy4}, 32'd0);
    in_data = 8'h44;
    tick();
    #1;
    chk("t4_yv4", {28'd0, yv4}, 32'h1);
    chk("t4_yd4", {24'd0, yd4[7:0]}, 32'h44);
    in_valid = 0;
    tick();

    // T5: 260 out-of-range beats into the 3-channel instance
    rst = 1; tick(); rst = 0;
    in_valid = 1; in_sel = 3; in_last = 1; in_data = 8'h55;
    for (int i = 0; i < 260; i++) begin
      #1;
      chk("t5_rdy3", {31'd0, rdy3}, 32'd1);
      chk("t5_yv3", {29'd0, yv3}, 32'd0);
      tick();
      if (i == 253) chk("t5_drop254", {24'd0, dc3}, 32'd254);
      if (i == 254) chk("t5_drop255", {24'd0, dc3}, 32'd255);
    end
    #1 chk("t5_drop_sat", {24'd0, dc3}, 32'd255);
    in_valid = 0;

    // T6: reset during beat 2 of a channel-0 packet
    rst = 1; tick(); rst = 0;
    in_valid = 1; in_sel = 0; in_last = 0; in_data = 8'h61;
    tick();
    #1 chk("t6_busy_open", {31'd0, busy4}, 32'd1);
    rst = 1; in_data = 8'h62;
    #1 chk("t6_rdy_rst", {31'd0, rdy4}, 32'd0);
    tick();
    rst = 0; in_sel = 3; in_last = 1; in_data = 8'h63;
    #1 chk("t6_rdy", {31'd0, rdy4}, 32'd1);
    tick();
    #1;
    chk("t6_yv", {28'd0, yv4}, 32'h8);
    chk("t6_yd3", {24'd0, yd4[31:24]}, 32'h63);
    chk("t6_busy", {31'd0, busy4}, 32'd0);
    in_valid = 0;

    // Randomised traffic against the model
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 2'($urandom_range(0, 3));
      in_last  = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      yr4      = 4'($urandom);
      yr3      = 3'($urandom);
      #1 check_model();
      tick();
    end
    rst = 0; in_valid = 0;
    #1 check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
